// File: rtl/fnd_display_scheduler.sv
// FND display arbiter for the oven top level: done blink, overlays,
// countdown timer and idle animation share the 4-digit display.
module fnd_display_scheduler #(
  parameter int OVL_CYCLES  = 200_000_000,
  parameter int BLINK_HALF  = 50_000_000,
  parameter int BLINK_COUNT = 3,
  parameter int MAX_VALUE   = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        idle,
  input  logic [13:0] timer_value,
  input  logic        ovl_req,
  input  logic [13:0] ovl_data,
  output logic        ovl_ack,
  input  logic        done_pulse,
  input  logic        user_clear,
  output logic [13:0] disp_data,
  output logic        idle_animation,
  output logic        disp_blank,
  output logic [1:0]  state_o
);

  localparam int OW = (OVL_CYCLES > 1) ? $clog2(OVL_CYCLES) : 1;
  localparam int HW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int NW = (2 * BLINK_COUNT > 1) ? $clog2(2 * BLINK_COUNT) : 1;

  localparam logic [OW-1:0] OLAST = OW'(OVL_CYCLES - 1);
  localparam logic [HW-1:0] HLAST = HW'(BLINK_HALF - 1);
  localparam logic [NW-1:0] NLAST = NW'(2 * BLINK_COUNT - 1);
  localparam logic [13:0]   MAXV  = 14'(MAX_VALUE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TIMER = 2'd1,
    S_OVL   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [OW-1:0] ocnt, ocnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [NW-1:0] halves, halves_n;
  logic [13:0]   latch, latch_n;
  logic [13:0]   data_n;
  logic          anim_n;
  logic          blank_n;
  logic          ack_n;
  logic          accept;

  function automatic logic [13:0] clamp(input logic [13:0] v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // ack gating keeps a still-held request from being taken twice
  assign accept = ovl_req && !ovl_ack && (state != S_DONE);

  always_comb begin
    state_n  = state;
    ocnt_n   = ocnt;
    hcnt_n   = hcnt;
    halves_n = halves;
    latch_n  = latch;
    blank_n  = 1'b0;
    ack_n    = 1'b0;
    if (done_pulse) begin
      state_n  = S_DONE;
      hcnt_n   = '0;
      halves_n = '0;
    end else if (accept) begin
      state_n = S_OVL;
      latch_n = clamp(ovl_data);
      ocnt_n  = '0;
      ack_n   = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: if (!idle) state_n = S_TIMER;
        S_TIMER: if (idle) state_n = S_IDLE;
        S_OVL: begin
          if (ocnt == OLAST)
            state_n = idle ? S_IDLE : S_TIMER;
          else
            ocnt_n = ocnt + 1'b1;
        end
        S_DONE: begin
          if (user_clear) begin
            state_n = S_IDLE;
          end else if (hcnt == HLAST) begin
            hcnt_n = '0;
            if (halves == NLAST) begin
              state_n = S_IDLE;
            end else begin
              halves_n = halves + 1'b1;
              blank_n  = ~disp_blank;
            end
          end else begin
            hcnt_n  = hcnt + 1'b1;
            blank_n = disp_blank;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    data_n = '0;
    anim_n = 1'b0;
    unique case (state_n)
      S_IDLE:  anim_n = 1'b1;
      S_TIMER: data_n = clamp(timer_value);
      S_OVL:   data_n = latch_n;
      S_DONE:  data_n = '0;
      default: anim_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      ocnt           <= '0;
      hcnt           <= '0;
      halves         <= '0;
      latch          <= '0;
      disp_data      <= '0;
      idle_animation <= 1'b1;
      disp_blank     <= 1'b0;
      ovl_ack        <= 1'b0;
    end else begin
      state          <= state_n;
      ocnt           <= ocnt_n;
      hcnt           <= hcnt_n;
      halves         <= halves_n;
      latch          <= latch_n;
      disp_data      <= data_n;
      idle_animation <= anim_n;
      disp_blank     <= blank_n;
      ovl_ack        <= ack_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Randomized and directed bench for fnd_display_scheduler against
// a cycle-level behavioural model of the display arbitration.
module tb_fnd_display_scheduler;

  localparam int OVL = 10;
  localparam int BH  = 4;
  localparam int BC  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        idle;
  logic [13:0] timer_value;
  logic        ovl_req;
  logic [13:0] ovl_data;
  logic        ovl_ack;
  logic        done_pulse;
  logic        user_clear;
  logic [13:0] disp_data;
  logic        idle_animation;
  logic        disp_blank;
  logic [1:0]  state_o;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  fnd_display_scheduler #(
    .OVL_CYCLES(OVL),
    .BLINK_HALF(BH),
    .BLINK_COUNT(BC),
    .MAX_VALUE(9999)
  ) dut (
    .clk(clk),
    .reset(reset),
    .idle(idle),
    .timer_value(timer_value),
    .ovl_req(ovl_req),
    .ovl_data(ovl_data),
    .ovl_ack(ovl_ack),
    .done_pulse(done_pulse),
    .user_clear(user_clear),
    .disp_data(disp_data),
    .idle_animation(idle_animation),
    .disp_blank(disp_blank),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // behavioural model: states as ints, overlay as cycles left,
  // blink as elapsed cycles since done
  int          m_state = 0;
  int          ovl_left = 0;
  int          blink_t = 0;
  logic [13:0] m_latch = '0;
  bit          take;
  logic [13:0] exp_data = '0;
  logic        exp_anim = 1'b1;
  logic        exp_blank = 1'b0;
  logic        exp_ack = 1'b0;
  logic [1:0]  exp_state = '0;

  function automatic logic [13:0] clampv(input logic [13:0] v);
    return (v > 14'd9999) ? 14'd9999 : v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_state = 0;
      m_latch = '0;
      ovl_left = 0;
      blink_t = 0;
      exp_ack = 1'b0;
    end else begin
      take = ovl_req && !exp_ack && (m_state != 3);
      exp_ack = 1'b0;
      if (done_pulse) begin
        m_state = 3;
        blink_t = 0;
      end else if (take) begin
        m_state = 2;
        m_latch = clampv(ovl_data);
        ovl_left = OVL;
        exp_ack = 1'b1;
      end else begin
        case (m_state)
          0: if (!idle) m_state = 1;
          1: if (idle) m_state = 0;
          2: begin
            ovl_left--;
            if (ovl_left == 0) m_state = idle ? 0 : 1;
          end
          default: begin
            if (user_clear) begin
              m_state = 0;
            end else begin
              blink_t++;
              if (blink_t == 2 * BC * BH) m_state = 0;
            end
          end
        endcase
      end
    end
    exp_state = 2'(m_state);
    exp_data = (m_state == 1) ? clampv(timer_value) :
               (m_state == 2) ? m_latch : 14'd0;
    exp_anim = (m_state == 0);
    exp_blank = (m_state == 3) && (((blink_t / BH) % 2) == 1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("state", 32'(state_o), 32'(exp_state));
      cmp("data", 32'(disp_data), 32'(exp_data));
      cmp("anim", 32'(idle_animation), 32'(exp_anim));
      cmp("blank", 32'(disp_blank), 32'(exp_blank));
      cmp("ack", 32'(ovl_ack), 32'(exp_ack));
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    idle = 1'b1;
    timer_value = '0;
    ovl_req = 1'b0;
    ovl_data = '0;
    done_pulse = 1'b0;
    user_clear = 1'b0;
    tick();
    chk_en = 1;
    tick(2);
    cmp("rst_state", 32'(state_o), 32'd0);
    cmp("rst_anim", 32'(idle_animation), 32'd1);
    reset = 1'b0;

    // idle animation
    tick(20);
    cmp("idle_state", 32'(state_o), 32'd0);
    cmp("idle_data", 32'(disp_data), 32'd0);

    // countdown display with lag and saturation
    idle = 1'b0;
    timer_value = 14'd130;
    tick();
    cmp("tmr_state", 32'(state_o), 32'd1);
    cmp("tmr_130", 32'(disp_data), 32'd130);
    timer_value = 14'd129;
    tick();
    cmp("tmr_129", 32'(disp_data), 32'd129);
    timer_value = 14'd12000;
    tick();
    cmp("tmr_sat", 32'(disp_data), 32'd9999);

    // overlay and retrigger at overlay cycle 6
    ovl_req = 1'b1;
    ovl_data = 14'd7;
    tick();
    cmp("ovl_ack", 32'(ovl_ack), 32'd1);
    cmp("ovl_7", 32'(disp_data), 32'd7);
    ovl_req = 1'b0;
    tick(5);
    cmp("ovl_noack", 32'(ovl_ack), 32'd0);
    ovl_req = 1'b1;
    ovl_data = 14'd5;
    tick();
    cmp("ovl_5", 32'(disp_data), 32'd5);
    ovl_req = 1'b0;
    tick(9);
    cmp("ovl_last", 32'(state_o), 32'd2);
    tick();
    cmp("ovl_exit", 32'(state_o), 32'd1);
    cmp("ovl_exitd", 32'(disp_data), 32'd9999);

    // done during overlay: 4 visible / 4 blank, three times
    ovl_req = 1'b1;
    ovl_data = 14'd3;
    tick();
    ovl_req = 1'b0;
    tick(2);
    done_pulse = 1'b1;
    tick();
    done_pulse = 1'b0;
    cmp("dn_state", 32'(state_o), 32'd3);
    cmp("dn_blank0", 32'(disp_blank), 32'd0);
    tick(4);
    cmp("dn_blank1", 32'(disp_blank), 32'd1);
    tick(19);
    cmp("dn_end", 32'(state_o), 32'd3);
    tick();
    cmp("dn_exit", 32'(state_o), 32'd0);
    cmp("dn_anim", 32'(idle_animation), 32'd1);

    // held overlay during blink, aborted by user_clear
    done_pulse = 1'b1;
    tick();
    done_pulse = 1'b0;
    ovl_req = 1'b1;
    ovl_data = 14'd42;
    tick(9);
    cmp("bl_noack", 32'(ovl_ack), 32'd0);
    user_clear = 1'b1;
    tick();
    user_clear = 1'b0;
    cmp("bl_clr", 32'(state_o), 32'd0);
    tick();
    cmp("bl_ack", 32'(ovl_ack), 32'd1);
    cmp("bl_data", 32'(disp_data), 32'd42);
    ovl_req = 1'b0;

    // reset mid-overlay and mid-blink
    tick(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("rs_ovl", 32'(state_o), 32'd0);
    cmp("rs_ovld", 32'(disp_data), 32'd0);
    done_pulse = 1'b1;
    tick();
    done_pulse = 1'b0;
    tick(5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("rs_dn", 32'(state_o), 32'd0);
    cmp("rs_dnb", 32'(disp_blank), 32'd0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if (ovl_req && ovl_ack) begin
        ovl_req = 1'b0;
      end else if (!ovl_req && $urandom_range(0, 14) == 0) begin
        ovl_req = 1'b1;
        ovl_data = 14'($urandom);
      end
      done_pulse = ($urandom_range(0, 79) == 0);
      user_clear = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 15) == 0) idle = ~idle;
      if ($urandom_range(0, 3) == 0) timer_value = 14'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnd_display_scheduler.md
Name: fnd_display_scheduler

Overview:
Sequences the FND display path for the microwave oven top level. It decides each cycle what the 4-digit FND shows, and drives the FND controller's data and idle-animation inputs plus a blank control. Four sources share the display, in descending priority: cooking-done blink, short-lived overlays (e.g. power level, a setting being edited), the running countdown timer, and the idle circle animation. Overlays and blink are timed internally, so requesters only issue requests.

Parameters:
OVL_CYCLES, 200_000_000, overlay display duration in clk cycles (2 s at 100 MHz)
BLINK_HALF, 50_000_000, half-period of the done blink in clk cycles (0.5 s)
BLINK_COUNT, 3, number of full blink periods (visible + blank) before auto-exit
MAX_VALUE, 9999, saturation limit applied to any displayed value

Ports:
clk  input  1  100 MHz system clock
reset  input  1  synchronous, active-high reset
idle  input  1  oven FSM is in IDLE (level)
timer_value  input  14  countdown value, MMSS decimal-encoded (minutes*100+seconds)
ovl_req  input  1  overlay request; held by requester until ovl_ack
ovl_data  input  14  value to show during overlay; sampled on acceptance
ovl_ack  output  1  1-cycle pulse, overlay accepted
done_pulse  input  1  1-cycle pulse, cooking finished
user_clear  input  1  1-cycle pulse, any button press; aborts the done blink
disp_data  output  14  to FND controller input_data
idle_animation  output  1  to FND controller idle_animation
disp_blank  output  1  1 = top level forces all anodes off
state_o  output  2  current state: 0 IDLE_ANIM, 1 SHOW_TIMER, 2 OVERLAY, 3 DONE_BLINK

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset. All outputs are registered.
- Reset values: state IDLE_ANIM, disp_data 0, idle_animation 1, disp_blank 0, ovl_ack 0, all counters 0.
- Output latency: outputs reflect the state and inputs of the previous cycle (1 cycle).
- Saturation: any value routed to disp_data is clamped to MAX_VALUE.
- Next-state evaluation each cycle, in priority order:
  1. done_pulse: go to DONE_BLINK from any state. If already in DONE_BLINK, the blink counters restart.
  2. ovl_req (not in DONE_BLINK): go to OVERLAY, latch ovl_data, assert ovl_ack the following cycle, clear the overlay counter.
     - A new ovl_req while in OVERLAY re-latches the data, restarts the counter and is acked.
  3. Otherwise, per-state rules below.
- IDLE_ANIM:
  - Outputs: idle_animation=1, disp_data=0, disp_blank=0.
  - idle=0 goes to SHOW_TIMER.
- SHOW_TIMER:
  - Outputs: idle_animation=0, disp_blank=0, disp_data=clamp(timer_value) updated every cycle.
  - idle=1 goes to IDLE_ANIM.
- OVERLAY:
  - Outputs: idle_animation=0, disp_blank=0, disp_data=latched value.
  - Counter runs 0..OVL_CYCLES-1. On the terminal count, go to IDLE_ANIM if idle=1, else SHOW_TIMER.
- DONE_BLINK:
  - Outputs: idle_animation=0, disp_data=0 (shows 0000).
  - disp_blank starts at 0 (visible) and toggles every BLINK_HALF cycles.
  - After 2*BLINK_COUNT half-periods, go to IDLE_ANIM with disp_blank=0.
  - user_clear exits immediately to IDLE_ANIM.
  - ovl_req is ignored (no ack; the request stays pending) and is serviced after exit.
- Simultaneous events:
  - done_pulse with ovl_req: done wins, ovl_req stays pending, no ack.
  - done_pulse with user_clear: done wins (blink starts).
  - Overlay expiry with ovl_req in the same cycle: the request is taken and the overlay restarts.
- ovl_ack is never asserted on two consecutive cycles for one held request. The requester must drop ovl_req the cycle after ack.
- Reset mid-operation: return to reset values on the next edge. Latched overlay data and pending state are discarded.

Test Plan:
Use OVL_CYCLES=10, BLINK_HALF=4, BLINK_COUNT=3.
1. Reset, then idle=1 for 20 cycles -> state_o=0, idle_animation=1, disp_data=0, disp_blank=0 throughout.
2. idle=0, timer_value=130 then 129 -> state_o=1 one cycle later; disp_data tracks 130 then 129 with 1-cycle lag. timer_value=12000 -> disp_data=9999.
3. In SHOW_TIMER, ovl_req with ovl_data=7 -> ovl_ack pulses once, disp_data=7 for exactly 10 cycles, then returns to SHOW_TIMER showing timer_value. A second ovl_req (data 5) at overlay cycle 6 -> disp_data=5, 10-cycle window restarts.
4. done_pulse during OVERLAY -> state_o=3, disp_data=0, disp_blank pattern 4 low / 4 high repeated 3 times (24 cycles), then state_o=0 and idle_animation=1.
5. In DONE_BLINK, ovl_req held -> no ack during blink. user_clear at blink cycle 9 -> IDLE_ANIM next cycle, then the overlay is accepted and acked.
6. reset asserted mid-OVERLAY and mid-DONE_BLINK -> next cycle all outputs at reset values, state_o=0.
